boot_loader: RTL
================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, instruction-memory word-address width (matches the core PC width).
REQ-002 SHALL have parameter BASE_ADDR, default 0, instruction-memory word address of the first loaded word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port byte_in  input  8  incoming program-image byte.
REQ-006 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 SHALL have port imem_addr  output  ADDR_W  instruction-memory write word address.
REQ-009 SHALL have port imem_data  output  32  instruction-memory write data.
REQ-010 SHALL have port imem_wren  output  1  instruction-memory write enable, one-cycle pulse.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset to the processor core; low while loading.
REQ-012 SHALL have port done  output  1  image loaded and checksum good.
REQ-013 SHALL have port error  output  1  checksum mismatch detected.

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid=1 and byte_ready=1; byte_in is ignored otherwise.
REQ-015 SHALL parse the image in this order: LEN_HI, LEN_LO (16-bit word count N, big-endian), N*4 data bytes (each word big-endian, first byte = bits 31:24), then one checksum byte.
REQ-016 SHALL implement states LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
REQ-017 SHALL drive byte_ready=1 in LEN_HI, LEN_LO, DATA and CHECK, and byte_ready=0 in WRITE, DONE and ERR.
REQ-018 SHALL transition LEN_HI->LEN_LO and LEN_LO->(N=0 ? CHECK : DATA) on byte acceptance.
REQ-019 SHALL, in DATA, shift accepted bytes into a 32-bit word register and go to WRITE on acceptance of the 4th byte of a word.
REQ-020 SHALL, in WRITE, assert imem_wren for exactly one cycle with imem_addr = (BASE_ADDR + word_index) mod 2^ADDR_W and imem_data = the assembled word.
REQ-021 SHALL then increment word_index and go to CHECK if word_index+1 = N, else to DATA.
REQ-022 SHALL keep a running 8-bit XOR of all data bytes; length bytes are excluded.
REQ-023 SHALL, in CHECK, on acceptance compare byte_in to the XOR: equal -> DONE, unequal -> ERR.
REQ-024 SHALL hold imem_wren=0 in every state except WRITE; imem_addr and imem_data may hold their last values otherwise.
REQ-025 SHALL register core_rst_n, done and error: core_rst_n=1 and done=1 exactly while in DONE, and error=1 exactly while in ERR.
REQ-026 SHALL treat DONE and ERR as terminal; they are left only through rst_n.
REQ-027 SHALL support N up to 65535; the address wraps modulo 2^ADDR_W without error.

Reset
REQ-028 SHALL, on a rising edge with rst_n=0, enter LEN_HI and clear word_index, XOR, word register and N.
REQ-029 SHALL, during and after reset, drive byte_ready=0 during reset, imem_wren=0, imem_addr=0, imem_data=0, core_rst_n=0, done=0 and error=0.
REQ-030 SHALL discard a partially received image on reset mid-load, with no further imem_wren pulses.

Verification
REQ-031 SHALL pass this case: bytes 00 00 00 -> no imem_wren; done=1 and core_rst_n=1 one cycle after the checksum byte is accepted.
REQ-032 SHALL pass this case: bytes 00 01 12 34 56 78 08 -> one imem_wren with addr 0 and data 0x12345678, then done=1.
REQ-033 SHALL pass this case: bytes 00 02 DE AD BE EF 00 00 00 01 checksum 0x23 -> writes addr 0 = 0xDEADBEEF and addr 1 = 0x00000001, then done=1.
REQ-034 SHALL pass this case: image of REQ-032 with checksum 0x09 -> write to addr 0 still occurs; error=1, done=0, core_rst_n stays 0.
REQ-035 SHALL pass this case: byte_valid held high continuously -> byte_ready=0 during each WRITE cycle, no byte is lost or duplicated, and the written data is correct.
REQ-036 SHALL pass this case: rst_n pulsed low after 2 of 4 data bytes, then the REQ-032 image is sent -> exactly one write, addr 0 = 0x12345678, done=1.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses a length-prefixed, XOR-checksummed image,
// writes each big-endian word into instruction memory, then releases the core.
module boot_loader #(
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_wren,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       n_words;
  logic [15:0]       word_idx;
  logic [1:0]        byte_cnt;
  logic [7:0]        csum;
  logic [31:0]       word;
  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] wr_addr;

  // Ready is gated by rst_n so nothing is handshaken while reset is held.
  assign byte_ready = rst_n && (state == LEN_HI || state == LEN_LO ||
                                state == DATA   || state == CHECK);
  assign accept     = byte_valid && byte_ready;
  assign last_word  = ({1'b0, word_idx} + 17'd1) == {1'b0, n_words};
  assign wr_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);

  always_comb begin
    state_nx = state;
    case (state)
      LEN_HI: if (accept) state_nx = LEN_LO;
      LEN_LO: if (accept) state_nx = ({n_words[15:8], byte_in} == 16'd0) ? CHECK : DATA;
      DATA:   if (accept && byte_cnt == 2'd3) state_nx = WRITE;
      WRITE:  state_nx = last_word ? CHECK : DATA;
      CHECK:  if (accept) state_nx = (byte_in == csum) ? DONE : ERR;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LEN_HI;
      n_words    <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word       <= '0;
      imem_addr  <= '0;
      imem_data  <= '0;
      imem_wren  <= 1'b0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      // Status outputs track the next state so they line up with the state register.
      imem_wren  <= (state_nx == WRITE);
      core_rst_n <= (state_nx == DONE);
      done       <= (state_nx == DONE);
      error      <= (state_nx == ERR);
      case (state)
        LEN_HI: if (accept) n_words[15:8] <= byte_in;
        LEN_LO: if (accept) n_words[7:0]  <= byte_in;
        DATA: if (accept) begin
          word     <= {word[23:0], byte_in};
          csum     <= csum ^ byte_in;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_data <= {word[23:0], byte_in};
            imem_addr <= wr_addr;
          end
        end
        WRITE: word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
